mul_shift_add_16bit: RTL and testbench

Iterative 16×16→32 unsigned multiplier for the ALU's multi-cycle path. It runs the classic shift-and-add loop, one add-then-right-shift step per clock, and presents the product and two flags over a valid/ready handshake. When the remaining multiplier bits are all zero, an optional early-termination mode completes the job with a single variable right shift. The block sits downstream of operand fetch and beside the combinational ALU; its result feeds the ALU result mux.

---
 rtl/alu_pkg.sv | 14 +
 rtl/rshift_32bit.sv | 11 +
 rtl/mul_shift_add_16bit.sv | 126 ++++++++++++
 tb/tb_mul_shift_add_16bit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM state encoding and sizing constants.
// Imported by the shift-add multiplier and its helpers.
package alu_pkg;

  localparam int MUL_WIDTH = 16;
  localparam int MUL_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/rshift_32bit.sv
// Combinational 32-bit logical right shift, zero fill.
// Ports: i_data (32), i_amt (5) -> o_data (32).
module rshift_32bit (
  input  logic [31:0] i_data,
  input  logic [4:0]  i_amt,
  output logic [31:0] o_data
);

  assign o_data = i_data >> i_amt;

endmodule

// File: rtl/mul_shift_add_16bit.sv
// Iterative 16x16->32 unsigned shift-and-add multiplier, valid/ready in and out.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready, mcand, mplr;
//   out_valid/out_ready, product (32), zero, hi_nz.
// Option: define MUL_EARLY_TERM_EN to finish early once the multiplier is spent.
module mul_shift_add_16bit
  import alu_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               zero,
  output logic               hi_nz
);

  mul_state_e         r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH:0]   r_p;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_product;
  logic               r_zero;
  logic               r_hi_nz;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_hi;
  logic [2*WIDTH:0]   w_p_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_finish;
  logic [2*WIDTH-1:0] w_fin;

  assign w_addend   = r_m[0] ? r_a : '0;
  // P[32] is always 0 after a shift, so the 17-bit sum cannot overflow
  assign w_hi       = r_p[2*WIDTH:WIDTH] + {1'b0, w_addend};
  assign w_p_next   = {w_hi, r_p[WIDTH-1:0]} >> 1;
  assign w_cnt_next = r_cnt + CNT_W'(1);

`ifdef MUL_EARLY_TERM_EN
  logic [2*WIDTH-1:0] w_early;

  // Remaining iterations would only shift; do them in one step
  rshift_32bit u_rshift (
    .i_data (r_p[2*WIDTH-1:0]),
    .i_amt  (CNT_W'(WIDTH) - r_cnt),
    .o_data (w_early)
  );

  always_comb begin
    w_finish = (w_cnt_next == CNT_W'(WIDTH));
    w_fin    = w_p_next[2*WIDTH-1:0];
    if (r_m == '0) begin
      w_finish = 1'b1;
      w_fin    = w_early;
    end
  end
`else
  always_comb begin
    w_finish = (w_cnt_next == CNT_W'(WIDTH));
    w_fin    = w_p_next[2*WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_m         <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_product   <= '0;
      r_zero      <= 1'b0;
      r_hi_nz     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= mcand;
            r_m     <= mplr;
            r_p     <= '0;
            r_cnt   <= '0;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_p   <= w_p_next;
          r_m   <= r_m >> 1;
          r_cnt <= w_cnt_next;
          if (w_finish) begin
            r_product   <= w_fin;
            r_zero      <= (w_fin == '0);
            r_hi_nz     <= |w_fin[2*WIDTH-1:WIDTH];
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign product   = r_product;
  assign zero      = r_zero;
  assign hi_nz     = r_hi_nz;

endmodule

// File: tb/tb_mul_shift_add_16bit.sv
// Self-checking bench for mul_shift_add_16bit against a plain a*b model.
// Honours MUL_EARLY_TERM_EN for the expected latency.
module tb_mul_shift_add_16bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mcand;
  logic [15:0] mplr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        zero;
  logic        hi_nz;

  int total;
  int bad;

  mul_shift_add_16bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mcand     (mcand),
    .mplr      (mplr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .zero      (zero),
    .hi_nz     (hi_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model latency: early termination stops after the top set multiplier bit
  function automatic int model_lat(input logic [15:0] b);
    int h;
`ifdef MUL_EARLY_TERM_EN
    if (b == 16'd0) return 1;
    h = 0;
    for (int i = 0; i < 16; i++) if (b[i]) h = i;
    return (h + 2 > 16) ? 16 : h + 2;
`else
    h = b;
    return 16 + (h & 0);
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_p, input int exp_lat,
                        input int stall, input string tag);
    int edges;
    chk({tag, " in_ready before"}, {31'd0, in_ready}, 32'd1);
    mcand     = a;
    mplr      = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    mcand    = 16'($urandom);
    mplr     = 16'($urandom);
    edges    = 0;
    while (!out_valid && edges < 40) begin
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s busy in_ready: got %b want 0", tag, in_ready);
      end
      tick();
      edges++;
    end
    if (!out_valid) begin
      chk({tag, " timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    chk({tag, " latency"}, 32'(edges), 32'(exp_lat));
    chk({tag, " product"}, product, exp_p);
    chk({tag, " zero"}, 32'(zero), 32'(exp_p == 32'd0));
    chk({tag, " hi_nz"}, 32'(hi_nz), 32'(exp_p[31:16] != 16'd0));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      tick();
      chk({tag, " hold valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold product"}, product, exp_p);
      chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " delivered"}, 32'(out_valid), 32'd0);
    chk({tag, " ready again"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    int          lat35;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mcand     = 16'd0;
    mplr      = 16'd0;
    #12;
    chk("rst product", product, 32'h0);
    chk("rst zero", 32'(zero), 32'd0);
    chk("rst hi_nz", 32'(hi_nz), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

`ifdef MUL_EARLY_TERM_EN
    lat35 = 4;
    run_op(16'h1234, 16'h0000, 32'h0000_0000, 1, 0, "zero mplr");
    run_op(16'h00FF, 16'h0001, 32'h0000_00FF, 2, 0, "mplr one");
    run_op(16'h0010, 16'h0100, 32'h0000_1000, 10, 0, "mplr 0100");
`else
    lat35 = 16;
`endif
    run_op(16'h0003, 16'h0005, 32'h0000_000F, lat35, 0, "3x5");
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 16, 0, "max");
    run_op(16'h1234, 16'h0000, 32'h0000_0000, model_lat(16'h0), 0, "zero");
    run_op(16'h8001, 16'h8001, 32'h4001_0001, 16, 5, "backpressure");

    // Abort mid-calculation at iteration 7
    mcand    = 16'h1234;
    mplr     = 16'hFFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    repeat (20) begin
      tick();
      chk("abort no result", 32'(out_valid), 32'd0);
    end
    run_op(16'h0002, 16'h0003, 32'h0000_0006, model_lat(16'h3), 0,
           "after abort");

    for (int n = 0; n < 1000; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 7))
        0: a = 16'h0;
        1: b = 16'h0;
        2: b = 16'($urandom_range(0, 255));
        3: a = 16'hFFFF;
        default: ;
      endcase
      run_op(a, b, 32'(a) * 32'(b), model_lat(b),
             $urandom_range(0, 2), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
